// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
// Multi-cycle sequencer for the RV32I integer datapath (register file, ALU, PC).
// Each instruction passes through FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Fetch uses a req/ack handshake with a bounded wait. Only R-type and I-type
// ALU instructions are legal. Anything else, or a fetch that times out, ends in
// the terminal TRAP state.
//
// Build option:
//   CTRL_PERF_CNT_EN  when defined, cycle_cnt and instret_cnt are live 32-bit
//                     wrapping counters. When undefined, both ports are tied to
//                     zero and no counter flops are built.

module multicycle_ctrl_unit #(
    parameter int unsigned FETCH_TIMEOUT = 16   // 0 = wait for imem_ack forever
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instrCode,
    output logic        irWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcB,
    output logic        regFileWe,
    output logic        pcEn,
    output logic        instr_retired,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
);

    typedef enum logic [2:0] {
        S_RST_WAIT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] F7_ZERO  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Timeout counter only needs to reach FETCH_TIMEOUT-1.
    localparam int          TO_W     = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam bit          TO_EN    = (FETCH_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(FETCH_TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   to_cnt_q;

    // Only the fields this unit decodes are kept; register and immediate
    // fields are consumed by the datapath's own instruction register.
    logic [6:0]        opcode_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic              unused_instr_bits;

    logic [3:0]        alu_ctrl_q;
    logic              alu_src_b_q;
    logic [1:0]        trap_cause_q;

    logic              dec_legal;
    logic [3:0]        dec_alu_ctrl;
    logic              dec_src_b;
    logic              trap_load;
    logic [1:0]        trap_cause_d;

    assign unused_instr_bits = ^{instrCode[24:15], instrCode[11:7]};

    // Classify the latched instruction and form its ALU controls.
    always_comb begin
        // NOTE: every combinationally written signal gets a default first, so no
        // path through the case statements can leave it unassigned (no latch).
        dec_legal    = 1'b0;
        dec_src_b    = 1'b0;
        dec_alu_ctrl = {1'b0, funct3_q};
        case (opcode_q)
            OPC_R: begin
                dec_alu_ctrl = {funct7_q[5], funct3_q};
                if (funct7_q == F7_ZERO) begin
                    dec_legal = 1'b1;
                end else if (funct7_q == F7_ALT &&
                             (funct3_q == 3'b000 || funct3_q == 3'b101)) begin
                    dec_legal = 1'b1;
                end
            end
            OPC_I: begin
                dec_src_b = 1'b1;
                case (funct3_q)
                    3'b001: begin
                        dec_alu_ctrl = {funct7_q[5], funct3_q};
                        dec_legal    = (funct7_q == F7_ZERO);
                    end
                    3'b101: begin
                        dec_alu_ctrl = {funct7_q[5], funct3_q};
                        dec_legal    = (funct7_q == F7_ZERO) || (funct7_q == F7_ALT);
                    end
                    default: begin
                        // Upper immediate bits are data here, not an op modifier.
                        dec_legal = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
    end

    // Next-state and per-state enables of the sequencer.
    always_comb begin
        state_d       = state_q;
        imem_req      = 1'b0;
        irWe          = 1'b0;
        regFileWe     = 1'b0;
        pcEn          = 1'b0;
        instr_retired = 1'b0;
        trap_load     = 1'b0;
        trap_cause_d  = 2'b00;
        case (state_q)
            S_RST_WAIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // An ack on the last allowed cycle still wins over the timeout.
                    irWe    = 1'b1;
                    state_d = S_DECODE;
                end else if (TO_EN && to_cnt_q == TO_LAST) begin
                    state_d      = S_TRAP;
                    trap_load    = 1'b1;
                    trap_cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d      = S_TRAP;
                    trap_load    = 1'b1;
                    trap_cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                // rd = x0 still writes; the register file masks x0 on read.
                regFileWe     = 1'b1;
                pcEn          = 1'b1;
                instr_retired = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_RST_WAIT;
            end
        endcase
    end

    // State register; reset always restarts through RST_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RST_WAIT;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of block ordering.
            state_q <= state_d;
        end
    end

    // Fetch wait counter: counts cycles spent in FETCH, clears on leaving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q == S_FETCH && state_d == S_FETCH) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    // Capture the decode fields of the instruction accepted in FETCH.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: these are a handful of control flops, not a memory array, so
        // they take the async reset like the rest of the state.
        if (reset) begin
            opcode_q <= '0;
            funct3_q <= '0;
            funct7_q <= '0;
        end else if (irWe) begin
            opcode_q <= instrCode[6:0];
            funct3_q <= instrCode[14:12];
            funct7_q <= instrCode[31:25];
        end
    end

    // ALU controls: loaded in DECODE, held through WRITEBACK, zero otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_ctrl_q  <= '0;
            alu_src_b_q <= 1'b0;
        end else if (state_q == S_DECODE && dec_legal) begin
            alu_ctrl_q  <= dec_alu_ctrl;
            alu_src_b_q <= dec_src_b;
        end else if (state_q == S_WRITEBACK) begin
            alu_ctrl_q  <= '0;
            alu_src_b_q <= 1'b0;
        end
    end

    // Sticky trap cause, captured on entry to TRAP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trap_cause_q <= 2'b00;
        end else if (trap_load) begin
            trap_cause_q <= trap_cause_d;
        end
    end

    assign aluControl = alu_ctrl_q;
    assign aluSrcB    = alu_src_b_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = trap_cause_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] instret_cnt_q;

    // Free-running cycle and retire counters; both wrap at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (instr_retired) begin
                instret_cnt_q <= instret_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = 32'd0;
    assign instret_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// tb_multicycle_ctrl_unit
// Directed bench for multicycle_ctrl_unit. Inputs change and outputs are
// sampled on the falling clock edge; state advances on the rising edge.

module tb_multicycle_ctrl_unit;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_SUB    = 32'h402081B3;
    localparam logic [31:0] I_SRAI   = 32'h40335293;
    localparam logic [31:0] I_SRLI   = 32'h00335293;
    localparam logic [31:0] I_ADDI   = 32'h00500093;
    localparam logic [31:0] I_ADDIM1 = 32'hFFF00093;
    localparam logic [31:0] I_ANDI   = 32'hFFF0F093;
    localparam logic [31:0] I_ADDX0  = 32'h00000033;
    localparam logic [31:0] I_JAL    = 32'h0000006F;
    localparam logic [31:0] I_MUL    = 32'h02000033;
    localparam logic [31:0] I_RSLLA  = 32'h40001033;
    localparam logic [31:0] I_SLLIA  = 32'h40001013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] instrCode;
    logic        irWe;
    logic [3:0]  aluControl;
    logic        aluSrcB;
    logic        regFileWe;
    logic        pcEn;
    logic        instr_retired;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    multicycle_ctrl_unit #(.FETCH_TIMEOUT(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_ack      (imem_ack),
        .instrCode     (instrCode),
        .irWe          (irWe),
        .aluControl    (aluControl),
        .aluSrcB       (aluSrcB),
        .regFileWe     (regFileWe),
        .pcEn          (pcEn),
        .instr_retired (instr_retired),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Assert reset, check everything is zero, release, and walk RST_WAIT -> FETCH.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_outputs", 32'({imem_req, irWe, aluControl, aluSrcB, regFileWe,
                                  pcEn, instr_retired, trap, trap_cause}), 32'd0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        check("rst_instret_cnt", instret_cnt, 32'd0);
        imem_ack  = 1'b0;
        instrCode = '0;
        @(negedge clk);
        check("rst_held_outputs", 32'({imem_req, regFileWe, pcEn, instr_retired}), 32'd0);
        reset = 1'b0;
        cyc   = 0;
        #1;
        check("rst_wait_req", 32'(imem_req), 32'd0);
        step();
        check("first_req", 32'(imem_req), 32'd1);
    endtask

    // Serve one fetch after 'waits' cycles without ack; leaves the DUT in DECODE.
    task automatic fetch(input logic [31:0] instr, input int waits);
        logic bad;
        bad      = 1'b0;
        imem_ack = 1'b0;
        #1;
        for (int i = 0; i < waits; i++) begin
            bad = bad | ~imem_req | irWe | trap;
            step();
        end
        check("fetch_wait_req", 32'(bad), 32'd0);
        imem_ack  = 1'b1;
        instrCode = instr;
        #1;
        check("fetch_ack_req", 32'(imem_req), 32'd1);
        check("fetch_irwe", 32'(irWe), 32'd1);
        step();
    endtask

    // One legal instruction from FETCH back to the next FETCH.
    task automatic run_legal(input string tag, input logic [31:0] instr, input int waits,
                             input logic [3:0] exp_alu, input logic exp_src_b);
        int t0;
        t0 = cyc;
        fetch(instr, waits);
        // DECODE: a stray ack with a different word must be ignored.
        imem_ack  = 1'b1;
        instrCode = I_JAL;
        #1;
        check({tag, "_dec_irwe"}, 32'(irWe), 32'd0);
        check({tag, "_dec_alu"}, 32'({aluControl, aluSrcB}), 32'd0);
        check({tag, "_dec_en"}, 32'({regFileWe, pcEn, instr_retired, imem_req}), 32'd0);
        step();
        // EXECUTE
        check({tag, "_ex_alu"}, 32'(aluControl), 32'(exp_alu));
        check({tag, "_ex_srcb"}, 32'(aluSrcB), 32'(exp_src_b));
        check({tag, "_ex_en"}, 32'({regFileWe, pcEn, instr_retired}), 32'd0);
        step();
        // WRITEBACK
        check({tag, "_wb_alu"}, 32'({aluControl, aluSrcB}), 32'({exp_alu, exp_src_b}));
        check({tag, "_wb_en"}, 32'({regFileWe, pcEn, instr_retired}), 32'b111);
        check({tag, "_retire_cycle"}, 32'(cyc - t0), 32'(waits + 3));
        step();
        // Next FETCH
        imem_ack = 1'b0;
        #1;
        check({tag, "_nf_req"}, 32'(imem_req), 32'd1);
        check({tag, "_nf_alu"}, 32'({aluControl, aluSrcB, instr_retired, trap}), 32'd0);
    endtask

    // Illegal instruction: trap after DECODE and stay quiet under stray acks.
    task automatic run_illegal(input string tag, input logic [31:0] instr);
        logic bad;
        fetch(instr, 0);
        imem_ack = 1'b0;
        #1;
        check({tag, "_dec_en"}, 32'({regFileWe, pcEn, trap}), 32'd0);
        step();
        check({tag, "_trap"}, 32'(trap), 32'd1);
        check({tag, "_cause"}, 32'(trap_cause), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 22; i++) begin
            imem_ack  = i[0];
            instrCode = I_ADD;
            #1;
            bad = bad | imem_req | irWe | regFileWe | pcEn | instr_retired
                      | (aluControl != 4'd0) | aluSrcB | ~trap | (trap_cause != 2'b01);
            step();
        end
        check({tag, "_quiet"}, 32'(bad), 32'd0);
        imem_ack = 1'b0;
    endtask

    initial begin
        logic bad;
        reset     = 1'b1;
        imem_ack  = 1'b0;
        instrCode = '0;
        @(negedge clk);

        // Basic ADD with immediate ack, then the decode table.
        do_reset();
        run_legal("add", I_ADD, 0, 4'b0000, 1'b0);
        run_legal("sub", I_SUB, 0, 4'b1000, 1'b0);
        run_legal("srai", I_SRAI, 0, 4'b1101, 1'b1);
        run_legal("srli", I_SRLI, 0, 4'b0101, 1'b1);
        run_legal("addi", I_ADDI, 0, 4'b0000, 1'b1);
        run_legal("addim1", I_ADDIM1, 0, 4'b0000, 1'b1);
        run_legal("andi", I_ANDI, 0, 4'b0111, 1'b1);
        run_legal("add_x0", I_ADDX0, 0, 4'b0000, 1'b0);

        // Delayed ack: 3 wait cycles.
        run_legal("wait3", I_ADD, 3, 4'b0000, 1'b0);

        // Illegal encodings.
        run_illegal("jal", I_JAL);
        do_reset();
        run_illegal("mul", I_MUL);
        do_reset();
        run_illegal("r_sll_alt", I_RSLLA);
        do_reset();
        run_illegal("slli_alt", I_SLLIA);

        // Fetch timeout: 16 FETCH cycles with no ack.
        do_reset();
        bad = 1'b0;
        for (int i = 1; i < 16; i++) begin
            bad = bad | ~imem_req | trap;
            step();
        end
        check("to_wait", 32'(bad), 32'd0);
        check("to_last_fetch", 32'({imem_req, trap}), 32'b10);
        step();
        check("to_trap", 32'(trap), 32'd1);
        check("to_cause", 32'(trap_cause), 32'd2);
        check("to_req_off", 32'(imem_req), 32'd0);
        step();
        check("to_cause_hold", 32'({trap, trap_cause}), 32'b110);

        // Ack on the 16th FETCH cycle wins; counter restarts for the next fetch.
        do_reset();
        run_legal("ack16a", I_ADD, 15, 4'b0000, 1'b0);
        run_legal("ack16b", I_ADDI, 15, 4'b0000, 1'b1);
        check("ack16_no_trap", 32'(trap), 32'd0);

        // Reset pulse during EXECUTE discards the instruction.
        do_reset();
        fetch(I_SUB, 0);
        step();
        check("mid_ex_alu", 32'(aluControl), 32'b1000);
        do_reset();
        run_legal("post_rst", I_ADD, 0, 4'b0000, 1'b0);

        // Ten back-to-back ADDs from reset.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            run_legal("b2b", I_ADD, 0, 4'b0000, 1'b0);
        end
`ifdef CTRL_PERF_CNT_EN
        check("perf_instret", instret_cnt, 32'd10);
        check("perf_cycle", cycle_cnt, 32'd41);
`else
        check("perf_instret_tied", instret_cnt, 32'd0);
        check("perf_cycle_tied", cycle_cnt, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
